// File: rtl/tcs3200_emulator_pkg.sv
// Shared encodings for the TCS3200 emulator: colour-select codes, FSM states
// and the saturating period counter helper.
package tcs3200_emulator_pkg;

  localparam logic [1:0] SEL_RED   = 2'b00;
  localparam logic [1:0] SEL_CLEAR = 2'b01;
  localparam logic [1:0] SEL_BLUE  = 2'b10;
  localparam logic [1:0] SEL_GREEN = 2'b11;

  localparam int unsigned PERIOD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_e;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (v == '1) ? v : v + PERIOD_W'(1);
  endfunction

endpackage

// File: rtl/tcs_half_period_regs.sv
// Bank of four half-period registers indexed by colour select; writes of 0
// are stored as 1 so a phase always lasts at least one cycle.
module tcs_half_period_regs
  import tcs3200_emulator_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned RED_HALF    = 100,
  parameter int unsigned GREEN_HALF  = 150,
  parameter int unsigned BLUE_HALF   = 200,
  parameter int unsigned CLEAR_HALF  = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [1:0]             wr_sel_i,
  input  logic [COUNT_WIDTH-1:0] wr_data_i,
  input  logic [1:0]             rd_sel_i,
  output logic [COUNT_WIDTH-1:0] rd_data_o
);

  logic [COUNT_WIDTH-1:0] half_q [4];
  logic [COUNT_WIDTH-1:0] wr_val;

  assign wr_val = (wr_data_i == '0) ? COUNT_WIDTH'(1) : wr_data_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      half_q[SEL_RED]   <= COUNT_WIDTH'(RED_HALF);
      half_q[SEL_GREEN] <= COUNT_WIDTH'(GREEN_HALF);
      half_q[SEL_BLUE]  <= COUNT_WIDTH'(BLUE_HALF);
      half_q[SEL_CLEAR] <= COUNT_WIDTH'(CLEAR_HALF);
    end else if (wr_en_i) begin
      half_q[wr_sel_i] <= wr_val;
    end
  end

  assign rd_data_o = half_q[rd_sel_i];

endmodule

// File: rtl/tcs3200_emulator.sv
// TCS3200 colour sensor stand-in: square wave whose half-period follows the
// selected channel, with a settle interval after enable or selection change.
module tcs3200_emulator
  import tcs3200_emulator_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = 24,
  parameter int unsigned SETTLE_TICKS = 64,
  parameter int unsigned RED_HALF     = 100,
  parameter int unsigned GREEN_HALF   = 150,
  parameter int unsigned BLUE_HALF    = 200,
  parameter int unsigned CLEAR_HALF   = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             colorSelect,
  input  logic                   cfgWrite,
  input  logic [1:0]             cfgChannel,
  input  logic [COUNT_WIDTH-1:0] cfgHalfPeriod,
  output logic                   frequencyOut,
  output logic                   active,
  output logic [7:0]             periodCount
);

  localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST = COUNT_WIDTH'(SETTLE_TICKS - 1);

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] active_half_q;
  logic [1:0]             prev_sel_q;
  logic [PERIOD_W-1:0]    period_q;
  logic [COUNT_WIDTH-1:0] sel_half;
  logic                   phase_done;
  logic                   sel_changed;

  tcs_half_period_regs #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .RED_HALF    (RED_HALF),
    .GREEN_HALF  (GREEN_HALF),
    .BLUE_HALF   (BLUE_HALF),
    .CLEAR_HALF  (CLEAR_HALF)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (cfgWrite),
    .wr_sel_i  (cfgChannel),
    .wr_data_i (cfgHalfPeriod),
    .rd_sel_i  (colorSelect),
    .rd_data_o (sel_half)
  );

  assign phase_done  = (cnt_q == active_half_q - COUNT_WIDTH'(1));
  assign sel_changed = (colorSelect != prev_sel_q);

  // Priority: reset, disable, select change, then normal phase sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      active_half_q <= '0;
      prev_sel_q    <= SEL_RED;
      period_q      <= '0;
    end else begin
      prev_sel_q <= colorSelect;
      if (!enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if (state_q != ST_IDLE && sel_changed) begin
        state_q  <= ST_SETTLE;
        cnt_q    <= '0;
        period_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end
          ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              state_q       <= ST_HIGH;
              cnt_q         <= '0;
              active_half_q <= sel_half;
            end else begin
              cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
          end
          ST_HIGH: begin
            if (phase_done) begin
              state_q       <= ST_LOW;
              cnt_q         <= '0;
              active_half_q <= sel_half;
            end else begin
              cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
          end
          ST_LOW: begin
            if (phase_done) begin
              state_q       <= ST_HIGH;
              cnt_q         <= '0;
              active_half_q <= sel_half;
              period_q      <= sat_inc(period_q);
            end else begin
              cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Pure decodes of the state register, so they cannot glitch.
  assign frequencyOut = (state_q == ST_HIGH);
  assign active       = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign periodCount  = period_q;

endmodule

// File: tb/tb_tcs3200_emulator.sv
// Self-checking bench for tcs3200_emulator: run-length scoreboard for the
// square wave plus directed sequences for reset, config, disable and saturation.
module tb_tcs3200_emulator;

  localparam int unsigned CW        = 24;
  localparam int unsigned ST        = 4;
  localparam int          RUN_LIMIT = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    colorSelect;
  logic          cfgWrite;
  logic [1:0]    cfgChannel;
  logic [CW-1:0] cfgHalfPeriod;
  logic          frequencyOut;
  logic          active;
  logic [7:0]    periodCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    logic  lvl;
    int    len;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      name;
    logic [1:0] sel;
    int         half;
  } vec_t;
  vec_t tbl[4];

  tcs3200_emulator #(
    .COUNT_WIDTH  (CW),
    .SETTLE_TICKS (ST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .colorSelect   (colorSelect),
    .cfgWrite      (cfgWrite),
    .cfgChannel    (cfgChannel),
    .cfgHalfPeriod (cfgHalfPeriod),
    .frequencyOut  (frequencyOut),
    .active        (active),
    .periodCount   (periodCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input string name, input logic lvl, input int len);
    exp_t e;
    e.name = name;
    e.lvl  = lvl;
    e.len  = len;
    sb.push_back(e);
  endtask

  // Measure consecutive runs of frequencyOut starting at the current sample.
  task automatic drain_runs();
    exp_t e;
    int   len;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      len = 0;
      while (frequencyOut === e.lvl && len < RUN_LIMIT) begin
        len++;
        tick();
      end
      chk(e.name, len, e.len);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [CW-1:0] val);
    cfgWrite      = 1'b1;
    cfgChannel    = ch;
    cfgHalfPeriod = val;
    tick();
    cfgWrite      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sat_at;

    tbl[0] = '{"green", 2'b11, 150};
    tbl[1] = '{"blue",  2'b10, 200};
    tbl[2] = '{"clear", 2'b01, 50};
    tbl[3] = '{"red",   2'b00, 100};

    reset         = 1'b0;
    enable        = 1'b1;
    colorSelect   = 2'b00;
    cfgWrite      = 1'b0;
    cfgChannel    = 2'b00;
    cfgHalfPeriod = '0;

    // Reset held with enable high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_freq", frequencyOut, 0);
      chk("rst_active", active, 0);
      chk("rst_pcnt", periodCount, 0);
    end

    reset  = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    chk("idle_freq", frequencyOut, 0);

    // Red from idle: ST settle cycles, then first high
    enable = 1'b1;
    tick();
    for (int i = 0; i < int'(ST); i++) begin
      chk("settle_freq", frequencyOut, 0);
      chk("settle_active", active, 0);
      tick();
    end
    chk("first_high", frequencyOut, 1);
    chk("first_active", active, 1);
    repeat (599) tick();
    chk("red_pcnt_599", periodCount, 2);
    tick();
    chk("red_pcnt_600", periodCount, 3);
    chk("red_high_again", frequencyOut, 1);

    // Select changes, first one lands mid-HIGH
    repeat (30) tick();
    for (int v = 0; v < 4; v++) begin
      colorSelect = tbl[v].sel;
      tick();
      chk({tbl[v].name, "_drop"}, frequencyOut, 0);
      chk({tbl[v].name, "_pcnt_clr"}, periodCount, 0);
      push_run({tbl[v].name, "_settle"}, 1'b0, ST);
      push_run({tbl[v].name, "_high1"}, 1'b1, tbl[v].half);
      push_run({tbl[v].name, "_low1"}, 1'b0, tbl[v].half);
      push_run({tbl[v].name, "_high2"}, 1'b1, tbl[v].half);
      drain_runs();
      chk({tbl[v].name, "_pcnt1"}, periodCount, 1);
    end

    // Config write of 0 to blue mid-HIGH: old phase finishes, then period 2
    colorSelect = 2'b10;
    tick();
    push_run("cfg_settle", 1'b0, ST);
    drain_runs();
    repeat (49) tick();
    cfg_write(2'b10, '0);
    push_run("cfg_old_high", 1'b1, 150);
    push_run("cfg_low_a", 1'b0, 1);
    push_run("cfg_high_b", 1'b1, 1);
    push_run("cfg_low_b", 1'b0, 1);
    drain_runs();
    chk("cfg_pcnt", periodCount, 2);

    // Disable on the same edge as a select change
    enable      = 1'b0;
    colorSelect = 2'b11;
    tick();
    chk("dis_freq", frequencyOut, 0);
    chk("dis_active", active, 0);
    chk("dis_pcnt", periodCount, 2);
    repeat (3) tick();
    chk("idle_hold_pcnt", periodCount, 2);
    chk("idle_hold_freq", frequencyOut, 0);
    enable = 1'b1;
    tick();
    push_run("reen_settle", 1'b0, ST);
    push_run("reen_high", 1'b1, 150);
    push_run("reen_low", 1'b0, 150);
    drain_runs();

    // Saturation with clear half-period = 1
    cfg_write(2'b01, CW'(1));
    colorSelect = 2'b01;
    tick();
    chk("sat_pcnt_clr", periodCount, 0);
    sat_at = 1;
    while (periodCount !== 8'd255 && sat_at < 700) begin
      tick();
      sat_at++;
    end
    chk("sat_cycle", sat_at, 515);
    repeat (20) tick();
    chk("sat_hold", periodCount, 255);

    // Reset mid-oscillation loses the config write
    reset = 1'b0;
    tick();
    chk("mid_rst_freq", frequencyOut, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_pcnt", periodCount, 0);
    reset = 1'b1;
    tick();
    push_run("post_rst_settle", 1'b0, ST);
    push_run("post_rst_high", 1'b1, 50);
    drain_runs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcs3200_emulator.md
# tcs3200_emulator

Synthesizable stand-in for the TCS3200 colour sensor. It drives a square wave whose frequency depends on the sensor's {S3,S2} colour-select inputs, and models the sensor's settling after a selection change. It sits in place of the physical sensor, both on the board loopback header and in simulation. Its `frequencyOut` feeds the colour detector's `frequencyFromColorSensor`, and the detector's `colorSelect` drives this block.

## Interface
Parameters:
- `COUNT_WIDTH`, 24: width of half-period registers and the phase counter.
- `SETTLE_TICKS`, 64: cycles `frequencyOut` is held low after enable or a selection change. Legal range ≥1.
- `RED_HALF`, 100: reset half-period, in clk cycles, for select 2'b00.
- `GREEN_HALF`, 150: reset half-period for select 2'b11.
- `BLUE_HALF`, 200: reset half-period for select 2'b10.
- `CLEAR_HALF`, 50: reset half-period for select 2'b01.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  level; 1 = generate output.
- `colorSelect`  in  2  {S3,S2}: 00 red, 11 green, 10 blue, 01 clear.
- `cfgWrite`  in  1  single-cycle write strobe.
- `cfgChannel`  in  2  select code of the half-period register to write.
- `cfgHalfPeriod`  in  COUNT_WIDTH  new half-period value.
- `frequencyOut`  out  1  emulated sensor output.
- `active`  out  1  high while oscillating (states HIGH or LOW).
- `periodCount`  out  8  completed full periods since the last settle, saturating at 255.

## Operation
- Register bank: four half-period registers indexed by select code. Reset loads them with the `*_HALF` parameters.
- `cfgWrite`=1 writes `cfgHalfPeriod` into the `cfgChannel` entry at that edge. A written value of 0 is stored as 1.
- State machine has four states: IDLE, SETTLE, HIGH, LOW.
  - IDLE → SETTLE when `enable`=1.
  - SETTLE: counter runs 0..SETTLE_TICKS-1, then → HIGH.
  - HIGH: counter runs 0..H-1, then → LOW.
  - LOW: counter runs 0..H-1, then → HIGH. This LOW→HIGH transition increments `periodCount` (saturating).
- H is latched into `activeHalf` on every entry to HIGH or LOW, from the entry selected by the current `colorSelect`. A config write or select change therefore never alters a phase already in progress, except by the restart rule below.
- Select-change detection: `colorSelect` is registered each cycle as `prevSelect`. Any difference while not in IDLE forces → SETTLE with counter=0 and `periodCount`=0.
- `enable`=0 in any state → IDLE at the next edge, with counter=0 and `periodCount` held.
- Priority, highest first: reset, `enable`=0, select change, normal transition. A `cfgWrite` in the same cycle always completes.
- Outputs:
  - `frequencyOut` = (state==HIGH), decoded from the registered state, so it is glitch-free.
  - `active` = (state==HIGH || state==LOW).
- Counter compares are on full COUNT_WIDTH, unsigned. The counter never wraps, because H ≤ 2^COUNT_WIDTH-1.

## Timing
- Reset values:
  - state=IDLE, counter=0, `activeHalf`=0, `prevSelect`=00.
  - `frequencyOut`=0, `active`=0, `periodCount`=0.
  - Register bank = parameter defaults.
- `enable` sampled 1 at edge k:
  - SETTLE for cycles k+1 .. k+SETTLE_TICKS.
  - First HIGH cycle is k+SETTLE_TICKS+1.
- Steady state: exactly H cycles high, then H cycles low; period 2H.
- A select change presented at edge k forces `frequencyOut`=0 from k+1, and SETTLE runs its full length again.
- A select change during SETTLE restarts SETTLE.
- Reset asserted mid-phase: all outputs reach their reset values at the next edge. A config written before the reset is lost.

## Structure
- Shared package holds:
  - select encodings RED=2'b00, GREEN=2'b11, BLUE=2'b10, CLEAR=2'b01, the same values the colour detector uses;
  - the state encoding IDLE/SETTLE/HIGH/LOW.
- One sub-module, `tcs_half_period_regs`: a 4×COUNT_WIDTH bank with a write port, a combinational read port, and the zero-to-one clamp.
- The FSM, counter and `periodCount` stay in the top module.

## Test plan
1. Reset check (SETTLE_TICKS=4): hold `reset`=0 for 3 cycles with `enable`=1 → `frequencyOut`=0, `active`=0, `periodCount`=0 throughout.
2. Red default (`colorSelect`=00, `enable` rises at edge 10) → first high at cycle 15; high 100 cycles, low 100; `periodCount`=3 after 600 cycles of oscillation.
3. Select change: switch 00→11 mid-HIGH → `frequencyOut` low the next cycle; 4 settle cycles; then 150/150 square wave; `periodCount` reset to 0.
4. Config write: write channel 10 = 0 while blue is running → the current phase completes at its old H; following phases are 1 cycle high and 1 cycle low (period 2).
5. Disable and simultaneous events: `enable`=0 on the same edge as a select change → IDLE, output 0, `periodCount` held. Re-enable → SETTLE, then oscillation at the new channel's H.
6. Saturation: CLEAR_HALF override=1 → `periodCount` stops at 255 and does not wrap.
